// File: rtl/imem_boot_loader_if.sv
// Host-to-loader program word stream: valid/ready handshake plus start and last qualifiers.
interface imem_boot_loader_if;
  logic        host_start;
  logic        host_valid;
  logic [31:0] host_word;
  logic        host_last;
  logic        host_ready;

  modport master (
    output host_start,
    output host_valid,
    output host_word,
    output host_last,
    input  host_ready
  );

  modport slave (
    input  host_start,
    input  host_valid,
    input  host_word,
    input  host_last,
    output host_ready
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: streams host words into the imem load port,
// holds the CPU in reset while loading and for RESET_HOLD cycles afterwards.
module imem_boot_loader #(
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 8,
  parameter int RESET_HOLD = 4
) (
  input  logic                clk,
  input  logic                Reset,
  imem_boot_loader_if.slave   host,
  output logic                LoadInstructions,
  output logic [31:0]         Instruction,
  output logic [31:0]         load_addr,
  output logic                cpu_reset,
  output logic                running,
  output logic [ADDR_W:0]     word_count,
  output logic                load_err
);

  localparam int HoldW = $clog2(RESET_HOLD + 1);
  localparam logic [ADDR_W:0]  DepthCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [HoldW-1:0] HoldInit = HoldW'(RESET_HOLD);
  localparam logic [HoldW-1:0] HoldOne  = HoldW'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    ERR
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [HoldW-1:0] holdCnt;
  logic [HoldW-1:0] holdNext;
  logic [ADDR_W:0]  countNext;
  logic             strobeNext;
  logic [31:0]      instrNext;
  logic [31:0]      addrNext;
  logic             hostReady;
  logic             accept;

  // A start pulse always wins over a word offered in the same cycle.
  assign hostReady       = (state == LOAD) && !host.host_start && (word_count < DepthCnt);
  assign host.host_ready = hostReady;
  assign accept          = hostReady && host.host_valid;

  always_comb begin
    stateNext  = state;
    holdNext   = holdCnt;
    countNext  = word_count;
    strobeNext = 1'b0;
    instrNext  = Instruction;
    addrNext   = load_addr;

    case (state)
      IDLE: begin
        if (host.host_start) begin
          stateNext = LOAD;
          countNext = '0;
        end
      end

      LOAD: begin
        if (host.host_start) begin
          countNext = '0;
        end else if (accept) begin
          strobeNext = 1'b1;
          instrNext  = host.host_word;
          addrNext   = {{(30 - ADDR_W){1'b0}}, word_count[ADDR_W-1:0], 2'b00};
          countNext  = word_count + 1'b1;
          if (host.host_last) begin
            stateNext = HOLD;
            holdNext  = HoldInit;
          end
        end else if (host.host_valid && (word_count == DepthCnt)) begin
          stateNext = ERR;
        end
      end

      HOLD: begin
        if (host.host_start) begin
          stateNext = LOAD;
          countNext = '0;
        end else if (holdCnt <= HoldOne) begin
          stateNext = RUN;
          holdNext  = '0;
        end else begin
          holdNext = holdCnt - 1'b1;
        end
      end

      RUN, ERR: begin
        if (host.host_start) begin
          stateNext = LOAD;
          countNext = '0;
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // cpu_reset, running and load_err are decoded from the next state so they
  // change cleanly on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state            <= IDLE;
      holdCnt          <= '0;
      word_count       <= '0;
      LoadInstructions <= 1'b0;
      Instruction      <= '0;
      load_addr        <= '0;
      cpu_reset        <= 1'b1;
      running          <= 1'b0;
      load_err         <= 1'b0;
    end else begin
      state            <= stateNext;
      holdCnt          <= holdNext;
      word_count       <= countNext;
      LoadInstructions <= strobeNext;
      Instruction      <= instrNext;
      load_addr        <= addrNext;
      cpu_reset        <= (stateNext != RUN);
      running          <= (stateNext == RUN);
      load_err         <= (stateNext == ERR);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: default instance plus a DEPTH=4 instance for overflow.
module tb_imem_boot_loader;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  imem_boot_loader_if h0 ();
  imem_boot_loader_if h1 ();

  logic        ld0, cr0, run0, err0;
  logic [31:0] ins0, addr0;
  logic [8:0]  wc0;
  logic        ld1, cr1, run1, err1;
  logic [31:0] ins1, addr1;
  logic [2:0]  wc1;

  imem_boot_loader u0 (
    .clk(clk), .Reset(Reset), .host(h0.slave),
    .LoadInstructions(ld0), .Instruction(ins0), .load_addr(addr0),
    .cpu_reset(cr0), .running(run0), .word_count(wc0), .load_err(err0)
  );

  imem_boot_loader #(.DEPTH(4), .ADDR_W(2), .RESET_HOLD(4)) u1 (
    .clk(clk), .Reset(Reset), .host(h1.slave),
    .LoadInstructions(ld1), .Instruction(ins1), .load_addr(addr1),
    .cpu_reset(cr1), .running(run1), .word_count(wc1), .load_err(err1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOuts(input string tag);
    check({tag, " strobe"}, ld0, 0);
    check({tag, " instr"}, ins0, 0);
    check({tag, " addr"}, addr0, 0);
    check({tag, " wc"}, wc0, 0);
    check({tag, " cpu_reset"}, cr0, 1);
    check({tag, " running"}, run0, 0);
    check({tag, " load_err"}, err0, 0);
    check({tag, " ready"}, h0.host_ready, 0);
  endtask

  logic [31:0] prog [3] = '{32'h20010005, 32'h20020003, 32'h00221820};
  logic        tv   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] tw   [5] = '{32'h11111111, 32'hDEADBEEF, 32'h22222222, 32'hDEADBEEF, 32'h33333333};
  logic [31:0] ta   [5] = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h8};
  logic [8:0]  tc   [5] = '{9'd1, 9'd1, 9'd2, 9'd2, 9'd3};

  initial begin
    Reset = 1'b1;
    h0.host_start = 0; h0.host_valid = 0; h0.host_word = '0; h0.host_last = 0;
    h1.host_start = 0; h1.host_valid = 0; h1.host_word = '0; h1.host_last = 0;
    step();
    checkResetOuts("reset");

    // Basic 3-word load, valid every cycle
    Reset = 1'b0;
    h0.host_start = 1;
    step();
    h0.host_start = 0;
    h0.host_valid = 1;
    h0.host_word  = prog[0];
    #1;
    check("load ready", h0.host_ready, 1);
    for (int unsigned i = 0; i < 3; i++) begin
      h0.host_word = prog[i];
      h0.host_last = (i == 2);
      step();
      check("b2b strobe", ld0, 1);
      check("b2b instr", ins0, prog[i]);
      check("b2b addr", addr0, i * 4);
      check("b2b wc", wc0, i + 1);
    end
    h0.host_valid = 0;
    h0.host_last  = 0;
    check("hold cpu_reset first", cr0, 1);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("hold cpu_reset", cr0, 1);
      check("hold no strobe", ld0, 0);
      check("hold running", run0, 0);
    end
    step();
    check("release cpu_reset", cr0, 0);
    check("release running", run0, 1);
    check("run wc", wc0, 3);
    check("run ready", h0.host_ready, 0);

    // Restart from RUN, reload one word
    h0.host_start = 1;
    step();
    h0.host_start = 0;
    check("restart cpu_reset", cr0, 1);
    check("restart running", run0, 0);
    check("restart wc", wc0, 0);
    #1;
    check("restart ready", h0.host_ready, 1);
    h0.host_valid = 1; h0.host_word = 32'hCAFE0001; h0.host_last = 1;
    step();
    h0.host_valid = 0; h0.host_last = 0;
    check("reload strobe", ld0, 1);
    check("reload addr", addr0, 0);
    check("reload instr", ins0, 32'hCAFE0001);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("reload hold", cr0, 1);
    end
    step();
    check("reload release", cr0, 0);
    check("reload running", run0, 1);

    // Valid toggling 1,0,1,0,1
    h0.host_start = 1;
    step();
    h0.host_start = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      h0.host_valid = tv[i];
      h0.host_word  = tw[i];
      h0.host_last  = (i == 4);
      step();
      check("gap strobe", ld0, tv[i]);
      if (tv[i]) begin
        check("gap addr", addr0, ta[i]);
        check("gap instr", ins0, tw[i]);
      end
      check("gap wc", wc0, tc[i]);
    end
    h0.host_valid = 0; h0.host_last = 0;
    step();
    check("gap after strobe", ld0, 0);
    for (int unsigned i = 0; i < 3; i++) step();
    check("gap running", run0, 1);

    // host_start together with valid mid-load
    h0.host_start = 1;
    step();
    h0.host_start = 0;
    h0.host_valid = 1;
    h0.host_word = 32'hA0A0A0A0; step();
    h0.host_word = 32'hB0B0B0B0; step();
    check("mid wc2", wc0, 2);
    h0.host_start = 1;
    h0.host_word  = 32'hC0C0C0C0;
    #1;
    check("mid ready forced low", h0.host_ready, 0);
    step();
    check("mid no strobe", ld0, 0);
    check("mid wc cleared", wc0, 0);
    h0.host_start = 0;
    h0.host_word  = 32'hD0D0D0D0;
    step();
    check("mid restart strobe", ld0, 1);
    check("mid restart addr", addr0, 0);
    check("mid restart instr", ins0, 32'hD0D0D0D0);
    check("mid restart wc", wc0, 1);

    // Reset during LOAD with valid high
    h0.host_word = 32'hE0E0E0E0;
    Reset = 1'b1;
    step();
    checkResetOuts("rst in load");
    Reset = 1'b0;
    step();
    check("idle ignores valid strobe", ld0, 0);
    check("idle ignores valid wc", wc0, 0);
    h0.host_valid = 0;

    // Reset during HOLD
    h0.host_start = 1; step();
    h0.host_start = 0;
    h0.host_valid = 1; h0.host_word = 32'h12345678; h0.host_last = 1;
    step();
    check("pre-rst hold strobe", ld0, 1);
    h0.host_valid = 0; h0.host_last = 0;
    Reset = 1'b1;
    step();
    checkResetOuts("rst in hold");
    Reset = 1'b0;
    step();
    check("after rst still held", cr0, 1);

    // Overflow on DEPTH=4 instance
    h1.host_start = 1; step();
    h1.host_start = 0;
    h1.host_valid = 1;
    for (int unsigned i = 0; i < 4; i++) begin
      h1.host_word = 32'h100 + i;
      step();
      check("ovf strobe", ld1, 1);
      check("ovf addr", addr1, i * 4);
      check("ovf instr", ins1, 32'h100 + i);
      check("ovf wc", wc1, i + 1);
    end
    h1.host_word = 32'h104;
    #1;
    check("ovf full ready", h1.host_ready, 0);
    step();
    check("ovf no strobe", ld1, 0);
    check("ovf load_err", err1, 1);
    check("ovf cpu_reset", cr1, 1);
    check("ovf ready", h1.host_ready, 0);
    check("ovf wc held", wc1, 4);
    check("ovf addr held", addr1, 32'hC);
    step();
    check("err sticky", err1, 1);
    check("err no strobe", ld1, 0);
    h1.host_valid = 0;
    h1.host_start = 1;
    step();
    h1.host_start = 0;
    check("err clear", err1, 0);
    check("err wc clear", wc1, 0);
    check("err cpu_reset", cr1, 1);
    #1;
    check("err reload ready", h1.host_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
